roll_uart_tx: RTL and testbench

//   Serialises a finished die roll onto the UART line as ASCII text. Sits directly

---
 rtl/roll_uart_tx.sv | 171 +++++++++++++++++
 tb/tb_roll_uart_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/roll_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : roll_uart_tx
//  Purpose  : Sends a 5-bit die roll on a UART line as two ASCII decimal
//             digits followed by CR LF (4 bytes, 8N1, LSB first).
//  Revision : 1.0 - initial release
// ============================================================================
module roll_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [4:0] i_dieRoll,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       byte_q, byte_d;
    logic [4:0]       roll_q, roll_d;
    logic             tx_q, tx_d;
    logic             start_q;

    logic [1:0]       tens;
    logic [4:0]       tens_x10;
    logic [3:0]       ones;
    logic [7:0]       cur_byte;
    logic             cnt_last;
    logic             accept;

    // Decimal split of the latched roll and selection of the byte on the wire
    always_comb begin
        tens     = 2'd0;
        tens_x10 = 5'd0;
        if (roll_q >= 5'd30) begin
            tens     = 2'd3;
            tens_x10 = 5'd30;
        end else if (roll_q >= 5'd20) begin
            tens     = 2'd2;
            tens_x10 = 5'd20;
        end else if (roll_q >= 5'd10) begin
            tens     = 2'd1;
            tens_x10 = 5'd10;
        end
        ones = 4'(roll_q - tens_x10);
        case (byte_q)
            2'd0:    cur_byte = {6'b001100, tens};
            2'd1:    cur_byte = {4'h3, ones};
            2'd2:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    // A request is taken in IDLE, or in DONE when i_start has been held
    // high (not a fresh pulse) so back-to-back frames have no idle gap
    assign accept   = i_start && ((state_q == IDLE) || ((state_q == DONE) && start_q));
    assign cnt_last = (cnt_q == CNT_LAST);

    // Next-state, baud counter and registered line value
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        byte_d  = byte_q;
        roll_d  = roll_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (accept) begin
                    state_d = START;
                    roll_d  = i_dieRoll;
                    byte_d  = 2'd0;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = DATA;
                    bit_d   = 3'd0;
                    tx_d    = cur_byte[0];
                end
            end
            DATA: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_q + 3'd1];
                    end
                end
            end
            STOP: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (byte_q != 2'd3) begin
                        byte_d  = byte_q + 2'd1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = DONE;
                        tx_d    = 1'b1;
                    end
                end
            end
            DONE: begin
                cnt_d   = '0;
                tx_d    = 1'b1;
                state_d = IDLE;
                if (accept) begin
                    state_d = START;
                    roll_d  = i_dieRoll;
                    byte_d  = 2'd0;
                    tx_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State and datapath registers, cleared immediately by reset
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 2'd0;
            roll_q  <= 5'd0;
            tx_q    <= 1'b1;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            roll_q  <= roll_d;
            tx_q    <= tx_d;
            start_q <= i_start;
        end
    end

    assign o_tx   = tx_q;
    assign o_busy = (state_q != IDLE);
    assign o_done = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_roll_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_roll_uart_tx
//  Purpose  : Directed self-checking bench for roll_uart_tx (CLKS_PER_BIT=4)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_roll_uart_tx;

    localparam int C = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] roll;
    logic       tx;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    roll_uart_tx #(.CLKS_PER_BIT(C)) u_dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_start   (start),
        .i_dieRoll (roll),
        .o_tx      (tx),
        .o_busy    (busy),
        .o_done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after the accepting edge k; samples each bit mid-way,
    // checks every 10-bit frame, then the DONE cycle and the cycle after.
    task automatic capture_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                                 input bit expect_idle);
        logic [7:0] exp_b [4];
        logic [9:0] frame;
        exp_b[0] = b0;
        exp_b[1] = b1;
        exp_b[2] = 8'h0D;
        exp_b[3] = 8'h0A;
        for (int by = 0; by < 4; by++) begin
            frame = '0;
            for (int bi = 0; bi < 10; bi++) begin
                repeat (2) @(posedge clk);
                #1 frame[bi] = tx;
                repeat (2) @(posedge clk);
            end
            check($sformatf("%s_byte%0d", tag, by), {22'd0, frame}, {22'd0, 1'b1, exp_b[by], 1'b0});
        end
        // now exactly at edge k+40*C
        #1;
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
        check({tag, "_tx_in_done"}, {31'd0, tx}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_done_after"}, {31'd0, done}, 32'd0);
        if (expect_idle) begin
            check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
            check({tag, "_tx_after"}, {31'd0, tx}, 32'd1);
        end else begin
            check({tag, "_busy_b2b"}, {31'd0, busy}, 32'd1);
            check({tag, "_tx_b2b_start"}, {31'd0, tx}, 32'd0);
        end
    endtask

    // Pulse i_start for one cycle; returns just after the accepting edge
    task automatic send_roll(input string tag, input logic [4:0] r);
        @(posedge clk);
        #1;
        roll  = r;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_accept_tx"}, {31'd0, tx}, 32'd0);
        check({tag, "_accept_busy"}, {31'd0, busy}, 32'd1);
    endtask

    initial begin
        bit seen_done;
        bit seen_low;
        bit seen_busy;

        rst   = 1'b1;
        start = 1'b0;
        roll  = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        // 1. idle for 50 cycles
        seen_done = 1'b0;
        seen_low  = 1'b0;
        seen_busy = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            seen_done |= done;
            seen_low  |= ~tx;
            seen_busy |= busy;
        end
        check("idle_done", {31'd0, seen_done}, 32'd0);
        check("idle_txlow", {31'd0, seen_low}, 32'd0);
        check("idle_busy", {31'd0, seen_busy}, 32'd0);

        // 2. roll 7 -> "07\r\n"
        send_roll("r7", 5'd7);
        capture_frame("r7", 8'h30, 8'h37, 1'b1);

        // 3. further digit patterns
        send_roll("r19", 5'd19);
        capture_frame("r19", 8'h31, 8'h39, 1'b1);
        send_roll("r31", 5'd31);
        capture_frame("r31", 8'h33, 8'h31, 1'b1);
        send_roll("r0", 5'd0);
        capture_frame("r0", 8'h30, 8'h30, 1'b1);

        // 4. requests while busy are ignored; roll changes do not leak in
        send_roll("ign", 5'd12);
        fork
            capture_frame("ign", 8'h31, 8'h32, 1'b1);
            begin
                repeat (19) @(posedge clk);
                #2 start = 1'b1;
                roll = 5'd5;
                @(posedge clk);            // edge k+20 sees the pulse
                #2 start = 1'b0;
                repeat (140) @(posedge clk);
                #2 start = 1'b1;           // high during the DONE cycle
                @(posedge clk);            // edge k+161
                #2 start = 1'b0;
            end
        join
        seen_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 seen_busy |= busy;
        end
        check("ign_no_second", {31'd0, seen_busy}, 32'd0);

        // 5. i_start held high: second frame starts at edge k+161, roll
        //    latched again at that edge (changed mid-frame to 22)
        @(posedge clk);
        #1;
        roll  = 5'd19;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("held_accept_tx", {31'd0, tx}, 32'd0);
        fork
            capture_frame("held1", 8'h31, 8'h39, 1'b0);
            begin
                repeat (10) @(posedge clk);
                #2 roll = 5'd22;
            end
        join
        start = 1'b0;
        capture_frame("held2", 8'h32, 8'h32, 1'b1);

        // 6. asynchronous reset in the middle of byte1 data bits
        send_roll("rst_mid", 5'd31);
        repeat (50) @(posedge clk);        // edge k+50: byte1 data bit1 = 0
        #2;
        check("pre_rst_tx", {31'd0, tx}, 32'd0);
        #1 rst = 1'b1;
        #1;
        check("async_rst_tx", {31'd0, tx}, 32'd1);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send_roll("post_rst", 5'd28);
        capture_frame("post_rst", 8'h32, 8'h38, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
